serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `diff = a - b` as `a + ~b + 1`, LSB-first, one bit per clock through a single full-adder cell and a carry flop. It is the inverse-operation companion to the team's combinational full adder. It sits beside the lab ALU as an area-minimal, multi-cycle subtract unit with a valid/ready handshake on both sides. When enabled, it reports ARM-style N/Z/C/V flags.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The slave modport is the subtractor side. The master modport is the producer/consumer side.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, flags, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, flags, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor. It computes a - b = a + ~b + 1 LSB-first, one bit per clock.
// Define SERIAL_SUBTRACTOR_FLAGS_EN to build in the N/Z/C/V flag logic; otherwise flags reads 0.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Single full-adder cell fed with the inverted subtrahend bit.
  logic             x;
  logic             y;
  logic             s;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    x         = sa[0];
    y         = ~sb[0];
    s         = x ^ y ^ carry;
    carry_nxt = (x & y) | (carry & (x ^ y));
    res_nxt   = {s, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sa          <= '0;
      sb          <= '0;
      res         <= '0;
      carry       <= 1'b1;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sa         <= bus.a;
            sb         <= bus.b;
            carry      <= 1'b1;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.diff      = res;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic       a_msb;
  logic       b_msb;
  logic [3:0] flags_q;

  // Flags are resolved on the same edge that shifts in the last result bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      flags_q <= 4'b0000;
    end else if (state == IDLE && bus.in_valid) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == RUN && cnt == LAST) begin
      flags_q <= {s, (res_nxt == '0), carry_nxt, (a_msb != b_msb) & (s != a_msb)};
    end
  end

  assign bus.flags = flags_q;
`else
  assign bus.flags = 4'b0000;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with an arithmetic reference model and a per-cycle compare.
`timescale 1ns/1ps
module tb_serial_subtractor;
  localparam int unsigned W = 8;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fx(input logic [3:0] f);
    return FL_EN ? f : 4'b0000;
  endfunction

  function automatic logic [3:0] model_flags(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = 8'(a - b);
    if (!FL_EN) return 4'b0000;
    return {d[7], (d == 8'h00), (a >= b), (a[7] != b[7]) && (d[7] != a[7])};
  endfunction

  // Reference model: the result is a-b; the timing is "W cycles busy, then hold until taken".
  logic       m_ir = 1'b1, m_ov = 1'b0, m_busy = 1'b0, m_known = 1'b1;
  logic [7:0] m_diff = 8'h00;
  logic [3:0] m_flags = 4'h0;
  int         m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ir <= 1'b1; m_ov <= 1'b0; m_busy <= 1'b0; m_known <= 1'b1;
      m_diff <= 8'h00; m_flags <= 4'h0; m_left <= 0;
    end else if (m_ir) begin
      if (bus.in_valid) begin
        m_ir <= 1'b0; m_busy <= 1'b1; m_known <= 1'b0; m_left <= W;
        m_diff <= 8'(bus.a - bus.b);
        m_flags <= model_flags(bus.a, bus.b);
      end
    end else if (!m_ov) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_ov <= 1'b1; m_known <= 1'b1;
      end
    end else if (bus.out_ready) begin
      m_ov <= 1'b0; m_busy <= 1'b0; m_ir <= 1'b1; m_known <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", 32'(bus.in_ready), 32'(m_ir));
    check("cyc_out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("cyc_busy", 32'(bus.busy), 32'(m_busy));
    if (m_known) begin
      check("cyc_diff", 32'(bus.diff), 32'(m_diff));
      check("cyc_flags", 32'(bus.flags), 32'(m_flags));
    end
  end

  // One operation: accept, count the latency, check the result, stall optionally, then hand it off.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic [3:0] ef, input int stall);
    int cnt;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = 8'h5C;
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_latency"}, 32'(cnt), 32'(W));
    check({name, "_diff"}, 32'(bus.diff), 32'(ed));
    check({name, "_flags"}, 32'(bus.flags), 32'(fx(ef)));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = ~bus.a;
      @(negedge clk);
      check({name, "_stall_diff"}, 32'(bus.diff), 32'(ed));
      check({name, "_stall_flags"}, 32'(bus.flags), 32'(fx(ef)));
      check({name, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({name, "_stall_out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, "_done_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, "_done_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    reset_n = 1'b1;

    run_op("sub_5_3",   8'h05, 8'h03, 8'h02, 4'b0010, 0);
    run_op("sub_3_5",   8'h03, 8'h05, 8'hFE, 4'b1000, 0);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 4'b0011, 0);
    run_op("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 4'b1001, 0);
    run_op("sub_37_37", 8'h37, 8'h37, 8'h00, 4'b0110, 5);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h11; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_flags", 32'(bus.flags), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("sub_10_01", 8'h10, 8'h01, 8'h0F, 4'b0010, 0);
    run_op("sub_00_01", 8'h00, 8'h01, 8'hFF, 4'b1000, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
